// File: rtl/mod_74x169_cnt.sv
// Presettable synchronous up/down binary counter after the 74x169, active-high controls.
// Define MOD_74X169_SAT_EN to saturate at the terminal count instead of wrapping.
module mod_74x169_cnt #(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             LOAD,
  input  logic             UD,
  input  logic             ENP,
  input  logic             ENT,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             RCO
);

  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

  generate
    if (WIDTH < 2 || WIDTH > 16) begin : g_width_check
      $error("mod_74x169_cnt: WIDTH must be within 2..16");
    end
  endgenerate

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic             tc;
  logic             cnt_en;

  // Terminal count depends on direction: all-ones going up, zero going down.
  assign tc     = UD ? (q_q == ALL_ONES) : (q_q == '0);
  assign cnt_en = ENP & ENT;

  always_comb begin
    q_d = q_q;
    if (LOAD) begin
      q_d = D;
    end else if (cnt_en) begin
`ifdef MOD_74X169_SAT_EN
      if (!tc) begin
        q_d = UD ? (q_q + ONE) : (q_q - ONE);
      end
`else
      q_d = UD ? (q_q + ONE) : (q_q - ONE);
`endif
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign Q   = q_q;
  assign RCO = ENT & tc;

endmodule

// File: tb/tb_mod_74x169_cnt.sv
// Directed self-checking bench for mod_74x169_cnt, including an 8-bit cascade into an OR stage.
module tb_mod_74x169_cnt;

  logic       clk;
  logic       rst, load, ud, enp, ent;
  logic [3:0] d;
  logic [3:0] q;
  logic       rco;

  logic       c_rst;
  logic [3:0] q_lo, q_hi;
  logic       rco_lo, rco_hi;
  logic       y1;

  int checks = 0;
  int errors = 0;

  mod_74x169_cnt #(.WIDTH(4)) dut (
    .CLK(clk), .RST(rst), .LOAD(load), .UD(ud), .ENP(enp), .ENT(ent),
    .D(d), .Q(q), .RCO(rco)
  );

  mod_74x169_cnt #(.WIDTH(4)) u_lo (
    .CLK(clk), .RST(c_rst), .LOAD(1'b0), .UD(1'b1), .ENP(1'b1), .ENT(1'b1),
    .D(4'h0), .Q(q_lo), .RCO(rco_lo)
  );

  mod_74x169_cnt #(.WIDTH(4)) u_hi (
    .CLK(clk), .RST(c_rst), .LOAD(1'b0), .UD(1'b1), .ENP(1'b1), .ENT(rco_lo),
    .D(4'h0), .Q(q_hi), .RCO(rco_hi)
  );

  // Behavioural stand-in for the downstream OR gate section A1/B1 -> Y1.
  assign y1 = rco_lo | rco_hi;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; load = 1'b1; d = 4'hA; enp = 1'b1; ent = 1'b1; ud = 1'b0;
    c_rst = 1'b1;
    #2;

    // Reset overrides load and count enables
    tick();
    check("reset_q", 16'(q), 16'h0);
    check("reset_rco_down", 16'(rco), 16'h1);
    ud = 1'b1; #1;
    check("reset_rco_up", 16'(rco), 16'h0);

    // Load wins over counting
    rst = 1'b0; load = 1'b1; d = 4'h9; ud = 1'b1;
    tick();
    check("load_q", 16'(q), 16'h9);
    load = 1'b0;
    tick();
    check("count_1", 16'(q), 16'hA);
    tick();
    check("count_2", 16'(q), 16'hB);

    // Up wrap
    load = 1'b1; d = 4'hE;
    tick();
    check("load_e", 16'(q), 16'hE);
    check("rco_e", 16'(rco), 16'h0);
    load = 1'b0;
    tick();
    check("up_f", 16'(q), 16'hF);
    check("up_f_rco", 16'(rco), 16'h1);
    tick();
`ifdef MOD_74X169_SAT_EN
    check("up_sat", 16'(q), 16'hF);
    check("up_sat_rco", 16'(rco), 16'h1);
`else
    check("up_wrap", 16'(q), 16'h0);
    check("up_wrap_rco", 16'(rco), 16'h0);
`endif

    // Down wrap
    load = 1'b1; d = 4'h1; ud = 1'b0;
    tick();
    check("load_1", 16'(q), 16'h1);
    load = 1'b0;
    tick();
    check("down_0", 16'(q), 16'h0);
    check("down_0_rco", 16'(rco), 16'h1);
    tick();
`ifdef MOD_74X169_SAT_EN
    check("down_sat", 16'(q), 16'h0);
    check("down_sat_rco", 16'(rco), 16'h1);
`else
    check("down_wrap", 16'(q), 16'hF);
    check("down_wrap_rco", 16'(rco), 16'h0);
`endif

    // Enable gating at Q=F counting up
    load = 1'b1; d = 4'hF; ud = 1'b1;
    tick();
    load = 1'b0; enp = 1'b0; ent = 1'b1;
    tick();
    check("enp0_hold", 16'(q), 16'hF);
    check("enp0_rco", 16'(rco), 16'h1);
    enp = 1'b1; ent = 1'b0;
    tick();
    check("ent0_hold", 16'(q), 16'hF);
    check("ent0_rco", 16'(rco), 16'h0);
    ud = 1'b0; #1;
    check("ud_flip_rco_ent0", 16'(rco), 16'h0);

    // Direction change: RCO follows UD combinationally
    load = 1'b1; d = 4'h0; ent = 1'b1; ud = 1'b1;
    tick();
    load = 1'b0;
    check("ud_up_rco_at0", 16'(rco), 16'h0);
    ud = 1'b0; #1;
    check("ud_down_rco_at0", 16'(rco), 16'h1);
    ud = 1'b1;
    tick();
    check("count_from0", 16'(q), 16'h1);
    tick();
    check("count_to2", 16'(q), 16'h2);

    // Reset mid-count, then resume
    rst = 1'b1;
    tick();
    check("mid_reset", 16'(q), 16'h0);
    rst = 1'b0;
    tick();
    check("resume", 16'(q), 16'h1);

    // Load ignores UD and enables
    load = 1'b1; d = 4'h6; ud = 1'b0; enp = 1'b0; ent = 1'b0;
    tick();
    check("load_no_en", 16'(q), 16'h6);
    load = 1'b0;

    // 8-bit cascade
    tick();
    check("casc_reset", 16'({q_hi, q_lo}), 16'h00);
    c_rst = 1'b0;
    for (int i = 0; i < 255; i++) begin
      tick();
      if (i == 15) check("casc_16", 16'({q_hi, q_lo}), 16'h10);
    end
    check("casc_ff", 16'({q_hi, q_lo}), 16'hFF);
    check("casc_y1_hi", 16'(y1), 16'h1);
    check("casc_rco_hi", 16'(rco_hi), 16'h1);
    tick();
    check("casc_wrap", 16'({q_hi, q_lo}), 16'h00);
    check("casc_y1_lo", 16'(y1), 16'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
